coin_credit_accumulator: RTL and testbench

COIN_CREDIT_ACCUMULATOR -- requirements
Module: coin_credit_accumulator

---
 rtl/vm_pkg.sv | 19 +
 rtl/coin_decoder.sv | 16 +
 rtl/coin_credit_accumulator.sv | 118 +++++++++++
 tb/tb_coin_credit_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin encodings, coin values, FSM state encoding and credit width
// shared by the coin credit accumulator and its coin decoder.
package vm_pkg;
   localparam int CREDIT_W = 8;
   typedef enum logic [1:0] {
      COIN_5   = 2'b00,
      COIN_10  = 2'b01,
      COIN_25  = 2'b10,
      COIN_INV = 2'b11
   } coin_e;
   localparam logic [CREDIT_W-1:0] VAL_5  = 8'd1;
   localparam logic [CREDIT_W-1:0] VAL_10 = 8'd2;
   localparam logic [CREDIT_W-1:0] VAL_25 = 8'd5;
   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_COLLECT   = 2'b01,
      S_VEND_WAIT = 2'b10
   } state_e;
endpackage

// File: rtl/coin_decoder.sv
// coin_decoder: maps a coin_type code to its credit value in 5-cent units
// and flags the unused code; purely combinational.
module coin_decoder
   import vm_pkg::*;
(
   input  logic [1:0]          coin_type_i,
   output logic [CREDIT_W-1:0] value_o,
   output logic                invalid_o
);
   always_comb begin
      value_o   = coin_type_i == COIN_5  ? VAL_5  :
                  coin_type_i == COIN_10 ? VAL_10 :
                  coin_type_i == COIN_25 ? VAL_25 : '0;
      invalid_o = coin_type_i == COIN_INV;
   end
endmodule

// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator: vending credit FSM (IDLE/COLLECT/VEND_WAIT) with vend handshake and refunds.
// Optional idle auto-refund in COLLECT is enabled by defining COIN_TIMEOUT_EN.
module coin_credit_accumulator
   import vm_pkg::*;
#(
   parameter logic [CREDIT_W-1:0] MAX_CREDIT     = 8'd200,
   parameter int                  TIMEOUT_CYCLES = 1000
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin_type,
   input  logic                sel_valid,
   input  logic [CREDIT_W-1:0] price,
   input  logic                cancel,
   input  logic                vend_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic                vend_req,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                coin_reject
);
   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] price_q, price_d;
   logic                vend_req_q, vend_req_d;
   logic                change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
   logic                coin_reject_q, coin_reject_d;
   logic [CREDIT_W-1:0] coin_val;
   logic                coin_inv;
   logic [CREDIT_W:0]   sum;
   logic                timeout_hit;
   logic                do_cancel;
   logic                do_sel;
   logic                coin_ok;

   coin_decoder u_dec (
      .coin_type_i (coin_type),
      .value_o     (coin_val),
      .invalid_o   (coin_inv)
   );

`ifdef COIN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   assign timeout_hit = state_q == S_COLLECT && !coin_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign tmo_d       = (state_q == S_COLLECT && !coin_valid) ? tmo_q + 1'b1 : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Event priority: cancel (or timeout) > select > coin; a coin loses only to an event that acts.
   assign sum       = {1'b0, credit_q} + {1'b0, coin_val};
   assign do_cancel = state_q == S_COLLECT && (cancel || timeout_hit);
   assign do_sel    = state_q == S_COLLECT && sel_valid && credit_q >= price && !do_cancel;
   assign coin_ok   = coin_valid && !coin_inv && sum <= {1'b0, MAX_CREDIT} &&
                      state_q != S_VEND_WAIT && !do_cancel && !do_sel;

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      price_d        = price_q;
      vend_req_d     = 1'b0;
      change_valid_d = 1'b0;
      change_amt_d   = '0;
      coin_reject_d  = coin_valid && !coin_ok;
      if (do_cancel) begin
         change_valid_d = 1'b1;
         change_amt_d   = credit_q;
         credit_d       = '0;
         state_d        = S_IDLE;
      end else if (do_sel) begin
         price_d    = price;
         vend_req_d = 1'b1;
         state_d    = S_VEND_WAIT;
      end else if (state_q == S_VEND_WAIT) begin
         vend_req_d     = !vend_ack;
         change_valid_d = vend_ack;
         change_amt_d   = vend_ack ? credit_q - price_q : '0;
         credit_d       = vend_ack ? '0 : credit_q;
         state_d        = vend_ack ? S_IDLE : S_VEND_WAIT;
      end else if (coin_ok) begin
         credit_d = sum[CREDIT_W-1:0];
         state_d  = S_COLLECT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         price_q        <= '0;
         vend_req_q     <= 1'b0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         coin_reject_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         price_q        <= price_d;
         vend_req_q     <= vend_req_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
         coin_reject_q  <= coin_reject_d;
      end
   end

   assign credit       = credit_q;
   assign vend_req     = vend_req_q;
   assign change_valid = change_valid_q;
   assign change_amt   = change_amt_q;
   assign coin_reject  = coin_reject_q;
endmodule

// File: tb/tb_coin_credit_accumulator.sv
// tb_coin_credit_accumulator: directed scenarios plus randomized traffic against
// a behavioural credit model; define COIN_TIMEOUT_EN to also exercise auto-refund.
module tb_coin_credit_accumulator;
   localparam int MAXC = 200;
   localparam int TO   = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_valid, sel_valid, cancel, vend_ack;
   logic [1:0] coin_type;
   logic [7:0] price;
   logic [7:0] credit, change_amt;
   logic       vend_req, change_valid, coin_reject;

   int n_checks = 0;
   int n_fail   = 0;

   int m_credit = 0;
   int m_price  = 0;
   bit m_vending = 0;
   int m_idle   = 0;
   int e_amt;
   bit e_cv, e_rej;

   coin_credit_accumulator #(.MAX_CREDIT(8'(MAXC)), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .sel_valid    (sel_valid),
      .price        (price),
      .cancel       (cancel),
      .vend_ack     (vend_ack),
      .credit       (credit),
      .vend_req     (vend_req),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .coin_reject  (coin_reject)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: credit>0 without a pending vend means collecting; a vend is pending until ack.
   task automatic model(input bit cv, input int ct, input bit sv, input int pr, input bit cn, input bit ak);
      int  val;
      bit  collecting, tmo;
      val        = ct == 0 ? 5 / 5 : ct == 1 ? 10 / 5 : ct == 2 ? 25 / 5 : 0;
      collecting = !m_vending && m_credit > 0;
      tmo        = 0;
`ifdef COIN_TIMEOUT_EN
      if (!collecting) m_idle = 0;
      else if (cv)     m_idle = 0;
      else             m_idle++;
      tmo = collecting && m_idle == TO;
`endif
      e_cv = 0; e_amt = 0; e_rej = 0;
      if (m_vending) begin
         e_rej = cv;
         if (ak) begin
            e_cv = 1; e_amt = m_credit - m_price; m_credit = 0; m_vending = 0;
         end
      end else if (collecting && (cn || tmo)) begin
         e_cv = 1; e_amt = m_credit; m_credit = 0; e_rej = cv;
      end else if (collecting && sv && m_credit >= pr) begin
         m_vending = 1; m_price = pr; e_rej = cv;
      end else if (cv) begin
         if (val == 0 || m_credit + val > MAXC) e_rej = 1;
         else m_credit += val;
      end
   endtask

   task automatic step(input bit cv, input int ct, input bit sv, input int pr, input bit cn, input bit ak);
      @(negedge clk);
      coin_valid = cv; coin_type = 2'(ct); sel_valid = sv; price = 8'(pr); cancel = cn; vend_ack = ak;
      @(posedge clk);
      model(cv, ct, sv, pr, cn, ak);
      #1;
      check("credit", int'(credit), m_credit);
      check("vend_req", int'(vend_req), int'(m_vending));
      check("change_valid", int'(change_valid), int'(e_cv));
      check("change_amt", int'(change_amt), e_amt);
      check("coin_reject", int'(coin_reject), int'(e_rej));
   endtask

   task automatic idle_step();
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic coin(input int ct);
      step(1, ct, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      {coin_valid, sel_valid, cancel, vend_ack} = '0;
      coin_type = '0; price = '0;
      #1;
      check("rst_credit", int'(credit), 0);
      check("rst_vend_req", int'(vend_req), 0);
      check("rst_change_valid", int'(change_valid), 0);
      check("rst_change_amt", int'(change_amt), 0);
      check("rst_coin_reject", int'(coin_reject), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      coin(2); check("c25", int'(credit), 5);
      coin(1); check("c10", int'(credit), 7);
      coin(0); check("c5", int'(credit), 8);

      step(0, 0, 1, 6, 0, 0); check("vend_req_on", int'(vend_req), 1);
      idle_step();
      coin(0); check("coin_in_vend_rej", int'(coin_reject), 1);
      step(0, 0, 0, 0, 0, 1);
      check("vend_done_cv", int'(change_valid), 1);
      check("vend_done_amt", int'(change_amt), 2);
      check("vend_done_credit", int'(credit), 0);
      check("vend_done_req", int'(vend_req), 0);
      idle_step(); check("cv_one_pulse", int'(change_valid), 0);

      repeat (39) coin(2);
      repeat (2) coin(1);
      check("at199", int'(credit), 199);
      coin(1); check("over_max_rej", int'(coin_reject), 1);
      check("over_max_hold", int'(credit), 199);
      coin(3); check("inv_rej_199", int'(coin_reject), 1);
      coin(0); check("exact_max", int'(credit), 200);
      step(0, 0, 0, 0, 1, 0); check("refund200", int'(change_amt), 200);
      coin(3); check("inv_rej_idle", int'(coin_reject), 1);

      coin(1); coin(1);
      step(0, 0, 1, 6, 0, 0); check("sel_short_noreq", int'(vend_req), 0);
      step(0, 0, 0, 0, 1, 0); check("cancel_amt4", int'(change_amt), 4);

      coin(1);
      step(1, 2, 1, 1, 1, 0);
      check("tri_cv", int'(change_valid), 1);
      check("tri_amt", int'(change_amt), 2);
      check("tri_rej", int'(coin_reject), 1);
      check("tri_noreq", int'(vend_req), 0);

      coin(2);
      step(0, 0, 1, 3, 0, 0); check("pre_rst_req", int'(vend_req), 1);
      @(negedge clk);
      {coin_valid, sel_valid, cancel, vend_ack} = '0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", int'(vend_req), 0);
      check("async_rst_credit", int'(credit), 0);
      check("async_rst_cv", int'(change_valid), 0);
      m_credit = 0; m_vending = 0; m_idle = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_step();

`ifdef COIN_TIMEOUT_EN
      coin(0);
      repeat (8) idle_step();
      coin(1);
      repeat (9) idle_step();
      check("tmo_restart_nocv", int'(change_valid), 0);
      idle_step();
      check("tmo_cv", int'(change_valid), 1);
      check("tmo_amt", int'(change_amt), 3);
`else
      coin(0);
      repeat (50) idle_step();
      check("hold_credit", int'(credit), 1);
      step(0, 0, 0, 0, 1, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 45, int'($urandom_range(3)), $urandom_range(99) < 15,
              int'($urandom_range(30)), $urandom_range(99) < 4, $urandom_range(99) < 30);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
